// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the multicycle main control unit and the 16-bit datapath.
// The control unit is the master; the datapath and its memory port form the slave side.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 16
) ();
  logic [2:0]       opcode;
  logic [3:0]       funct;
  logic             zero;
  logic             mem_ready;
  // Counter preload port (bring-up and test access to the retired-instruction counter)
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;

  logic [1:0]       alu_op;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             pc_write;
  logic             ir_write;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             iord;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             pc_source;
  logic             instr_done;
  logic             illegal_instr;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired_count;

  modport master (
    input  opcode, funct, zero, mem_ready, cnt_load, cnt_load_val,
    output alu_op, alu_src_a, alu_src_b, pc_write, ir_write, mem_read, mem_write,
           reg_write, iord, reg_dst, mem_to_reg, pc_source, instr_done,
           illegal_instr, state, retired_count
  );

  modport slave (
    output opcode, funct, zero, mem_ready, cnt_load, cnt_load_val,
    input  alu_op, alu_src_a, alu_src_b, pc_write, ir_write, mem_read, mem_write,
           reg_write, iord, reg_dst, mem_to_reg, pc_source, instr_done,
           illegal_instr, state, retired_count
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle main control FSM: fetch/decode/execute/memory/writeback sequencing,
// datapath enables, ALUOp generation and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_control_fsm_if.master    bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_WB_MEM    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_WB_ALU    = 4'd8,
    S_BRANCH    = 4'd9,
    S_TRAP      = 4'd10
  } state_e;

  // Pure state-decoded outputs; the MemReady/Zero-gated strobes are added afterwards.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       pc_source;
    logic       instr_done;
    logic       illegal_instr;
  } moore_t;

  function automatic logic is_legal_rtype(input logic [3:0] funct);
    logic legal;
    case (funct)
      4'b0000, 4'b0001, 4'b1101, 4'b0010: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
    return legal;
  endfunction

  // The opcode argument only matters for WB_ALU, which writes rd for R-type and rt otherwise.
  function automatic moore_t decode_moore(input state_e st, input logic [2:0] opcode);
    moore_t m;
    m = '0;
    case (st)
      S_FETCH: begin
        m.mem_read  = 1'b1;
        m.alu_src_b = 2'b01;
      end
      S_DECODE: begin
        m.alu_src_b = 2'b11;
      end
      S_MEM_ADDR: begin
        m.alu_src_a = 1'b1;
        m.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        m.mem_read = 1'b1;
        m.iord     = 1'b1;
      end
      S_WB_MEM: begin
        m.reg_write  = 1'b1;
        m.mem_to_reg = 1'b1;
        m.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        m.mem_write = 1'b1;
        m.iord      = 1'b1;
      end
      S_EXEC_R: begin
        m.alu_src_a = 1'b1;
        m.alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        m.alu_src_a = 1'b1;
        m.alu_src_b = 2'b10;
        m.alu_op    = 2'b11;
      end
      S_WB_ALU: begin
        m.reg_write  = 1'b1;
        m.reg_dst    = (opcode == 3'b000);
        m.instr_done = 1'b1;
      end
      S_BRANCH: begin
        m.alu_src_a  = 1'b1;
        m.alu_op     = 2'b01;
        m.pc_source  = 1'b1;
        m.instr_done = 1'b1;
      end
      S_TRAP: begin
        m.illegal_instr = 1'b1;
      end
      default: begin
        m = '0;
      end
    endcase
    return m;
  endfunction

  state_e           state_r;
  state_e           state_next_s;
  moore_t           moore_r;
  moore_t           moore_s;
  logic             pc_write_s;
  logic             ir_write_s;
  logic             instr_done_s;
  logic [CNT_W-1:0] retired_count_r;

  // Next-state selection from the current state, opcode/funct and MemReady.
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (bus.mem_ready) state_next_s = S_DECODE;
        else               state_next_s = S_FETCH;
      end
      S_DECODE: begin
        case (bus.opcode)
          3'b000: begin
            if (is_legal_rtype(bus.funct)) state_next_s = S_EXEC_R;
            else                           state_next_s = S_TRAP;
          end
          3'b001, 3'b010, 3'b011, 3'b100: state_next_s = S_EXEC_I;
          3'b101, 3'b110:                 state_next_s = S_MEM_ADDR;
          3'b111:                         state_next_s = S_BRANCH;
          default:                        state_next_s = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        if (bus.opcode == 3'b110)      state_next_s = S_MEM_WRITE;
        else if (bus.opcode == 3'b101) state_next_s = S_MEM_READ;
        else                           state_next_s = S_FETCH;
      end
      S_MEM_READ: begin
        if (bus.mem_ready) state_next_s = S_WB_MEM;
        else               state_next_s = S_MEM_READ;
      end
      S_MEM_WRITE: begin
        if (bus.mem_ready) state_next_s = S_FETCH;
        else               state_next_s = S_MEM_WRITE;
      end
      S_EXEC_R, S_EXEC_I:           state_next_s = S_WB_ALU;
      S_WB_MEM, S_WB_ALU,
      S_BRANCH, S_TRAP:             state_next_s = S_FETCH;
      default:                      state_next_s = S_FETCH;
    endcase
  end

  // State register plus the state-decoded outputs registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
      moore_r <= decode_moore(S_FETCH, bus.opcode);
    end else begin
      state_r <= state_next_s;
      moore_r <= decode_moore(state_next_s, bus.opcode);
    end
  end

  // Combine registered decode with the in-cycle gated strobes; reset silences everything.
  always_comb begin
    moore_s      = '0;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    instr_done_s = 1'b0;
    if (rst) begin
      moore_s      = '0;
      pc_write_s   = 1'b0;
      ir_write_s   = 1'b0;
      instr_done_s = 1'b0;
    end else begin
      moore_s      = moore_r;
      ir_write_s   = (state_r == S_FETCH) & bus.mem_ready;
      pc_write_s   = ((state_r == S_FETCH) & bus.mem_ready) |
                     ((state_r == S_BRANCH) & (bus.zero ^ bus.funct[0]));
      instr_done_s = moore_r.instr_done | ((state_r == S_MEM_WRITE) & bus.mem_ready);
    end
  end

  // Retired-instruction counter; a preload takes priority over a retirement in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_count_r <= {CNT_W{1'b0}};
    end else if (bus.cnt_load) begin
      retired_count_r <= bus.cnt_load_val;
    end else if (instr_done_s) begin
      retired_count_r <= retired_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_count_r <= retired_count_r;
    end
  end

  assign bus.alu_op        = moore_s.alu_op;
  assign bus.alu_src_a     = moore_s.alu_src_a;
  assign bus.alu_src_b     = moore_s.alu_src_b;
  assign bus.pc_write      = pc_write_s;
  assign bus.ir_write      = ir_write_s;
  assign bus.mem_read      = moore_s.mem_read;
  assign bus.mem_write     = moore_s.mem_write;
  assign bus.reg_write     = moore_s.reg_write;
  assign bus.iord          = moore_s.iord;
  assign bus.reg_dst       = moore_s.reg_dst;
  assign bus.mem_to_reg    = moore_s.mem_to_reg;
  assign bus.pc_source     = moore_s.pc_source;
  assign bus.instr_done    = instr_done_s;
  assign bus.illegal_instr = moore_s.illegal_instr;
  assign bus.state         = state_r;
  assign bus.retired_count = retired_count_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: the driver queues hand-computed per-cycle
// expectations, and a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control_fsm;

  // Control vector layout:
  // {alu_op[1:0], src_a, src_b[1:0], pcw, irw, mrd, mwr, rgw, iord, rdst, m2r, pcs, done, ill}
  localparam logic [15:0] C_ZERO      = 16'b00_0_00_00000_0000_00;
  localparam logic [15:0] C_FETCH     = 16'b00_0_01_11100_0000_00;
  localparam logic [15:0] C_FETCH_W   = 16'b00_0_01_00100_0000_00;
  localparam logic [15:0] C_DEC       = 16'b00_0_11_00000_0000_00;
  localparam logic [15:0] C_EXR       = 16'b10_1_00_00000_0000_00;
  localparam logic [15:0] C_EXI       = 16'b11_1_10_00000_0000_00;
  localparam logic [15:0] C_WBR       = 16'b00_0_00_00001_0100_10;
  localparam logic [15:0] C_WBI       = 16'b00_0_00_00001_0000_10;
  localparam logic [15:0] C_MADDR     = 16'b00_1_10_00000_0000_00;
  localparam logic [15:0] C_MRD       = 16'b00_0_00_00100_1000_00;
  localparam logic [15:0] C_WBM       = 16'b00_0_00_00001_0010_10;
  localparam logic [15:0] C_MWR_W     = 16'b00_0_00_00010_1000_00;
  localparam logic [15:0] C_MWR_D     = 16'b00_0_00_00010_1000_10;
  localparam logic [15:0] C_BR_T      = 16'b01_1_00_10000_0001_10;
  localparam logic [15:0] C_BR_N      = 16'b01_1_00_00000_0001_10;
  localparam logic [15:0] C_TRAP      = 16'b00_0_00_00000_0000_01;

  typedef struct {
    int          idx;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cycle_idx;
  exp_t exp_q[$];

  multicycle_control_fsm_if #(.CNT_W(16)) bus ();

  multicycle_control_fsm #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      errors = errors + 1;
      $display("FAIL %s cycle %0d: got %b, expected %b", name, idx, act, expv);
    end
  endtask

  // Monitor: every cycle the DUT presents a full control word; compare it to the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] act_ctl;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act_ctl = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_write, bus.ir_write,
                 bus.mem_read, bus.mem_write, bus.reg_write, bus.iord, bus.reg_dst,
                 bus.mem_to_reg, bus.pc_source, bus.instr_done, bus.illegal_instr};
      chk("state", e.idx, {12'd0, bus.state}, {12'd0, e.st});
      chk("ctl", e.idx, act_ctl, e.ctl);
      chk("retired", e.idx, bus.retired_count, e.cnt);
    end
  end

  // One clock of stimulus: drive inputs, queue the expectation, advance past the next rising edge.
  task automatic cyc(input logic r, input logic z, input logic mr,
                     input logic [3:0] es, input logic [15:0] ec, input logic [15:0] en);
    exp_t e;
    rst           = r;
    bus.zero      = z;
    bus.mem_ready = mr;
    e.idx = cycle_idx;
    e.st  = es;
    e.ctl = ec;
    e.cnt = en;
    exp_q.push_back(e);
    cycle_idx = cycle_idx + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [3:0] fn);
    bus.opcode = op;
    bus.funct  = fn;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    cycle_idx        = 0;
    rst              = 1'b1;
    bus.opcode       = 3'b000;
    bus.funct        = 4'b0000;
    bus.zero         = 1'b0;
    bus.mem_ready    = 1'b1;
    bus.cnt_load     = 1'b0;
    bus.cnt_load_val = 16'h0000;
    @(posedge clk);
    #1;

    // Reset held for three cycles: everything quiet, state FETCH, counter zero.
    set_instr(3'b000, 4'b0000);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 4'd0, C_ZERO, 16'd0);

    // ADD: FETCH, DECODE, EXEC_R, WB_ALU (rd).
    cyc(1'b0, 1'b0, 1'b1, 4'd0, C_FETCH, 16'd0);
    cyc(1'b0, 1'b0, 1'b1, 4'd1, C_DEC,   16'd0);
    cyc(1'b0, 1'b0, 1'b1, 4'd6, C_EXR,   16'd0);
    cyc(1'b0, 1'b0, 1'b1, 4'd8, C_WBR,   16'd0);

    // LW with three wait cycles in MEM_READ: 8 cycles in total.
    set_instr(3'b101, 4'b0000);
    cyc(1'b0, 1'b0, 1'b1, 4'd0, C_FETCH, 16'd1);
    cyc(1'b0, 1'b0, 1'b1, 4'd1, C_DEC,   16'd1);
    cyc(1'b0, 1'b0, 1'b1, 4'd2, C_MADDR, 16'd1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'd3, C_MRD, 16'd1);
    cyc(1'b0, 1'b0, 1'b1, 4'd3, C_MRD,   16'd1);
    cyc(1'b0, 1'b0, 1'b1, 4'd4, C_WBM,   16'd1);

    // BEQ taken (Zero=1, Funct[0]=0): PCWrite in BRANCH.
    set_instr(3'b111, 4'b0000);
    cyc(1'b0, 1'b1, 1'b1, 4'd0, C_FETCH, 16'd2);
    cyc(1'b0, 1'b1, 1'b1, 4'd1, C_DEC,   16'd2);
    cyc(1'b0, 1'b1, 1'b1, 4'd9, C_BR_T,  16'd2);

    // BNE not taken (Zero=1, Funct[0]=1).
    set_instr(3'b111, 4'b0001);
    cyc(1'b0, 1'b1, 1'b1, 4'd0, C_FETCH, 16'd3);
    cyc(1'b0, 1'b1, 1'b1, 4'd1, C_DEC,   16'd3);
    cyc(1'b0, 1'b1, 1'b1, 4'd9, C_BR_N,  16'd3);

    // ADDI with one fetch stall; MemReady low in EXEC_I must be ignored.
    set_instr(3'b011, 4'b0101);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, C_FETCH_W, 16'd4);
    cyc(1'b0, 1'b0, 1'b1, 4'd0, C_FETCH,   16'd4);
    cyc(1'b0, 1'b0, 1'b1, 4'd1, C_DEC,     16'd4);
    cyc(1'b0, 1'b0, 1'b0, 4'd7, C_EXI,     16'd4);
    cyc(1'b0, 1'b0, 1'b1, 4'd8, C_WBI,     16'd4);

    // Illegal R-type funct 0111: TRAP, counter unchanged.
    set_instr(3'b000, 4'b0111);
    cyc(1'b0, 1'b0, 1'b1, 4'd0,  C_FETCH, 16'd5);
    cyc(1'b0, 1'b0, 1'b1, 4'd1,  C_DEC,   16'd5);
    cyc(1'b0, 1'b0, 1'b1, 4'd10, C_TRAP,  16'd5);

    // SW with one wait cycle; InstrDone only in the MemReady cycle.
    set_instr(3'b110, 4'b0000);
    cyc(1'b0, 1'b0, 1'b1, 4'd0, C_FETCH, 16'd5);
    cyc(1'b0, 1'b0, 1'b1, 4'd1, C_DEC,   16'd5);
    cyc(1'b0, 1'b0, 1'b1, 4'd2, C_MADDR, 16'd5);
    cyc(1'b0, 1'b0, 1'b0, 4'd5, C_MWR_W, 16'd5);
    cyc(1'b0, 1'b0, 1'b1, 4'd5, C_MWR_D, 16'd5);

    // SW interrupted by reset in MEM_WRITE: write dropped, FETCH and zero count next.
    cyc(1'b0, 1'b0, 1'b1, 4'd0, C_FETCH, 16'd6);
    cyc(1'b0, 1'b0, 1'b1, 4'd1, C_DEC,   16'd6);
    cyc(1'b0, 1'b0, 1'b1, 4'd2, C_MADDR, 16'd6);
    cyc(1'b1, 1'b0, 1'b1, 4'd5, C_ZERO,  16'd6);

    // Preload 0xFFFE during a stalled fetch, then retire two branches to wrap.
    bus.cnt_load     = 1'b1;
    bus.cnt_load_val = 16'hFFFE;
    cyc(1'b0, 1'b0, 1'b0, 4'd0, C_FETCH_W, 16'd0);
    bus.cnt_load     = 1'b0;
    set_instr(3'b111, 4'b0000);
    cyc(1'b0, 1'b0, 1'b1, 4'd0, C_FETCH, 16'hFFFE);
    cyc(1'b0, 1'b0, 1'b1, 4'd1, C_DEC,   16'hFFFE);
    cyc(1'b0, 1'b0, 1'b1, 4'd9, C_BR_N,  16'hFFFE);
    set_instr(3'b111, 4'b0001);
    cyc(1'b0, 1'b0, 1'b1, 4'd0, C_FETCH, 16'hFFFF);
    cyc(1'b0, 1'b0, 1'b1, 4'd1, C_DEC,   16'hFFFF);
    cyc(1'b0, 1'b0, 1'b1, 4'd9, C_BR_T,  16'hFFFF);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, C_FETCH_W, 16'h0000);

    // Let the monitor drain the last entry, then confirm nothing was left unchecked.
    @(negedge clk);
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
